// File: rtl/mem_bus_ctrl.sv
// Data-memory controller: valid/ready requests, one-entry posted write buffer with
// read forwarding, and fixed-latency pipelined RAM reads returned as a one-cycle strobe.
module mem_bus_ctrl #(
  parameter int DEPTH_LOG2 = 6,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic                  wb_valid;
  logic [DEPTH_LOG2-1:0] wb_idx;
  logic [31:0]           wb_data;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] last_addr;
  logic [31:0]           last_wdata;
  logic [CW-1:0]         cnt;
  logic                  accept, drain, issue, hit, rd_done;
  logic                  unused_addr_bits;

  assign req_idx          = req_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign drain     = wb_valid && (state != RD_ISSUE);
  assign issue     = (state == RD_ISSUE);
  // Forwarding looks at the buffer as it stands this cycle, even if it is draining now.
  assign hit       = wb_valid && (wb_idx == req_idx);
  assign rd_done   = (state == RD_WAIT) && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = last_addr;
    ram_wdata = last_wdata;
    rsp_valid = (state == RESP);

    case (state)
      IDLE:     if (accept && !req_write) state_nxt = hit ? RESP : RD_ISSUE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (rd_done) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    if (drain) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wb_idx;
      ram_wdata = wb_data;
    end else if (issue) begin
      ram_en   = 1'b1;
      ram_addr = rd_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid   <= 1'b0;
      wb_idx     <= '0;
      wb_data    <= '0;
      rd_idx     <= '0;
      cnt        <= '0;
      rsp_rdata  <= '0;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      if (accept && req_write) begin
        wb_valid <= 1'b1;
        wb_idx   <= req_idx;
        wb_data  <= req_wdata;
      end else if (drain) begin
        wb_valid <= 1'b0;
      end

      if (accept && !req_write) begin
        rd_idx <= req_idx;
        if (hit) rsp_rdata <= wb_data;
      end

      if (issue)
        cnt <= CW'(RD_LAT - 1);
      else if ((state == RD_WAIT) && (cnt != '0))
        cnt <= cnt - 1'b1;

      if (rd_done) rsp_rdata <= ram_rdata;

      // Address/data pins keep their last driven value while the RAM is idle.
      if (ram_en) begin
        last_addr  <= ram_addr;
        last_wdata <= ram_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: transaction-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_mem_bus_ctrl;
  localparam int DL = 6;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [DL-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  int checks = 0;
  int failures = 0;

  mem_bus_ctrl #(.DEPTH_LOG2(DL), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 24) return 32'hDEADBEEF;
    return (i * 32'h01010101) + 32'h0000_0100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Environment RAM with RD_LAT pipeline
  logic [31:0] ram_mem [64];
  bit          ram_wr  [64];
  logic [31:0] rd_pipe [RL];
  assign ram_rdata = rd_pipe[RL-1];

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_wr[ram_addr]  <= 1'b1;
    end
    rd_pipe[0] <= (ram_en && !ram_we) ?
                  (ram_wr[ram_addr] ? ram_mem[ram_addr] : init_word(int'(ram_addr))) :
                  32'h0BAD0BAD;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model: schedule of what each accepted request must cause and when
  logic [31:0] ref_mem [64];
  bit          ref_wr  [64];
  longint      cyc = 0;
  longint      rsp_at = -1, ready_at = 0, issue_at = -1;
  logic        dr_v = 1'b0, new_dv, m_acc;
  logic [5:0]  dr_i = '0, rd_i = '0, m_idx;
  logic [31:0] dr_d = '0, rsp_d = '0;
  logic        e_ready = 1'b0, e_rsp_valid = 1'b0, e_en = 1'b0, e_we = 1'b0;
  logic [31:0] e_rsp_data = '0, e_wdata = '0;
  logic [5:0]  e_addr = '0;

  function automatic logic [31:0] ref_rd(input logic [5:0] i);
    return ref_wr[i] ? ref_mem[i] : init_word(int'(i));
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      dr_v = 1'b0; rsp_at = -1; issue_at = -1; ready_at = 0;
      e_ready = 1'b1; e_rsp_valid = 1'b0; e_rsp_data = '0;
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    end else begin
      if (dr_v) begin
        ref_mem[dr_i] = dr_d;
        ref_wr[dr_i]  = 1'b1;
      end
      m_acc  = req_valid && e_ready;
      m_idx  = req_addr[7:2];
      new_dv = m_acc && req_write;
      if (m_acc && !req_write) begin
        if (dr_v && dr_i == m_idx) begin
          rsp_at = cyc + 1;
          rsp_d  = dr_d;
        end else begin
          rsp_at   = cyc + RL + 2;
          issue_at = cyc + 1;
          rd_i     = m_idx;
          rsp_d    = ref_rd(m_idx);
        end
        ready_at = rsp_at + 1;
      end
      dr_v = new_dv;
      if (new_dv) begin
        dr_i = m_idx;
        dr_d = req_wdata;
      end
      e_ready     = (cyc + 1 >= ready_at);
      e_rsp_valid = (cyc + 1 == rsp_at);
      if (e_rsp_valid) e_rsp_data = rsp_d;
      e_en = 1'b0;
      e_we = 1'b0;
      if (dr_v) begin
        e_en = 1'b1; e_we = 1'b1; e_addr = dr_i; e_wdata = dr_d;
      end else if (cyc + 1 == issue_at) begin
        e_en = 1'b1; e_addr = rd_i;
      end
    end
    cyc++;
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (reset) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_wdata", ram_wdata, 0);
    end else begin
      check("req_ready", req_ready, e_ready);
      check("rsp_valid", rsp_valid, e_rsp_valid);
      check("rsp_rdata", rsp_rdata, e_rsp_data);
      check("ram_en", ram_en, e_en);
      if (e_en) check("ram_we", ram_we, e_we);
      check("ram_addr", ram_addr, e_addr);
      check("ram_wdata", ram_wdata, e_wdata);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output int waits);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 30) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: req_ready never rose for addr %h", a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic read_wait(input logic [31:0] a, output int lat, output logic [31:0] data,
                           output logic en1, output logic we1, output logic [5:0] addr1,
                           output int nready);
    int w;
    issue(1'b0, a, 32'h0, w);
    lat = -1; data = '0; nready = 0; en1 = 1'b0; we1 = 1'b0; addr1 = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        en1 = ram_en; we1 = ram_we; addr1 = ram_addr;
      end
      if (lat < 0 && !req_ready) nready++;
      if (rsp_valid && lat < 0) begin
        lat = k; data = rsp_rdata;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w0, w1, w2, lat, nrd, cnt;
    logic [31:0] d;
    logic en1, we1;
    logic [5:0] a1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready_lit", req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_release", req_ready, 1);
    @(posedge clk); #1;

    // Posted write reaches RAM the next cycle
    issue(1'b1, 32'h64, 32'd7, w0);
    @(negedge clk);
    check("t1_ram_en", ram_en, 1);
    check("t1_ram_we", ram_we, 1);
    check("t1_ram_addr", ram_addr, 25);
    check("t1_ram_wdata", ram_wdata, 7);
    check("t1_ready", req_ready, 1);
    @(posedge clk); #1;

    // Read miss
    read_wait(32'h60, lat, d, en1, we1, a1, nrd);
    check("t2_latency", lat, 4);
    check("t2_data", d, 32'hDEADBEEF);
    check("t2_c1_en", en1, 1);
    check("t2_c1_we", we1, 0);
    check("t2_c1_addr", a1, 24);
    check("t2_not_ready_cycles", nrd, 4);

    // Forwarded read hit
    issue(1'b1, 32'h64, 32'd7, w0);
    read_wait(32'h64, lat, d, en1, we1, a1, nrd);
    check("t3_latency", lat, 1);
    check("t3_data", d, 7);
    check("t3_no_ram_read", en1, 0);

    // Back-to-back writes
    issue(1'b1, 32'h00, 32'd1, w0);
    issue(1'b1, 32'h04, 32'd2, w1);
    issue(1'b1, 32'h08, 32'd3, w2);
    check("t4_wait1", w1, 0);
    check("t4_wait2", w2, 0);
    @(negedge clk);
    check("t4_last_addr", ram_addr, 2);
    @(posedge clk); #1;
    read_wait(32'h08, lat, d, en1, we1, a1, nrd);
    check("t4_read_data", d, 3);

    // Address aliasing
    issue(1'b1, 32'h100, 32'hA5, w0);
    @(negedge clk);
    check("t5_alias_addr", ram_addr, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    read_wait(32'h000, lat, d, en1, we1, a1, nrd);
    check("t5_latency", lat, 4);
    check("t5_data", d, 32'hA5);

    // Reset during RD_WAIT
    issue(1'b0, 32'h60, 32'h0, w0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("t6_async_ready", req_ready, 0);
    check("t6_async_en", ram_en, 0);
    check("t6_async_addr", ram_addr, 0);
    check("t6_async_rdata", rsp_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_ready_after", req_ready, 1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) cnt++;
      @(negedge clk);
    end
    check("t6_no_rsp", cnt, 0);
    @(posedge clk); #1;

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        req_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
        reset = 1'b0;
      end else begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_write = $urandom_range(0, 1) == 1;
        req_addr  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        req_wdata = $urandom;
        @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
